// File: rtl/sensor_session_scheduler.sv
// Ultrasonic ranging sequencer: fires trigger pulses, times the echo in rounded
// centimetres and finishes after N_OK consecutive measurements within TOL_CM of the target.
module sensor_session_scheduler #(
  parameter int unsigned TRIGGER_CYCLES = 500,
  parameter int unsigned CM_CYCLES      = 2941,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
  parameter int unsigned PERIOD_CYCLES  = 2_500_000,
  parameter int unsigned N_OK           = 5,
  parameter int unsigned TOL_CM         = 2,
  parameter int unsigned MAX_CM         = 400
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] target_cm,
  input  logic       echo,
  output logic       trigger,
  output logic [8:0] medida_cm,
  output logic       medida_pronta,
  output logic       timeout,
  output logic [2:0] ok_count,
  output logic       done,
  output logic [3:0] db_estado
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = $clog2(CM_CYCLES);

  localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIGGER_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PRESC_INIT  = CW'(CM_CYCLES / 2);
  localparam logic [CW-1:0] PRESC_LAST  = CW'(CM_CYCLES - 1);
  localparam logic [8:0]    CM_MAX      = 9'(MAX_CM);
  localparam logic [9:0]    TOL         = 10'(TOL_CM);
  localparam logic [2:0]    NOK         = 3'(N_OK);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_TRIG        = 4'd1,
    S_WAIT_RISE   = 4'd2,
    S_MEASURE     = 4'd3,
    S_EVAL        = 4'd4,
    S_TMO         = 4'd5,
    S_WAIT_PERIOD = 4'd6,
    S_DONE        = 4'd7
  } state_t;

  state_t        state;
  logic          echo_s1, echo_s2, echo_d;
  logic          rise, fall;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] presc, presc_step;
  logic [8:0]    cm, cm_step, target_q;
  logic signed [9:0] diff;
  logic [9:0]    abs_diff;
  logic [2:0]    ok_next;

  assign db_estado = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  // The clock on which the fall is seen still counts, so the MEASURE->EVAL
  // transition captures the post-increment value directly.
  always_comb begin
    rise       = echo_s2 & ~echo_d;
    fall       = ~echo_s2 & echo_d;
    presc_step = presc + 1'b1;
    cm_step    = cm;
    if (presc == PRESC_LAST) begin
      presc_step = '0;
      if (cm < CM_MAX) cm_step = cm + 1'b1;
    end
    diff     = $signed({1'b0, cm_step}) - $signed({1'b0, target_q});
    abs_diff = diff[9] ? 10'(-diff) : 10'(diff);
    ok_next  = (abs_diff <= TOL) ? ok_count + 1'b1 : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      trigger       <= 1'b0;
      medida_cm     <= '0;
      medida_pronta <= 1'b0;
      timeout       <= 1'b0;
      ok_count      <= '0;
      done          <= 1'b0;
      period_cnt    <= '0;
      tmo_cnt       <= '0;
      presc         <= '0;
      cm            <= '0;
      target_q      <= '0;
    end else begin
      medida_pronta <= 1'b0;
      timeout       <= 1'b0;
      if (!enable) begin
        state    <= S_IDLE;
        trigger  <= 1'b0;
        ok_count <= '0;
        done     <= 1'b0;
      end else begin
        if (period_cnt < PERIOD_LAST) period_cnt <= period_cnt + 1'b1;
        case (state)
          S_IDLE: begin
            target_q   <= target_cm;
            ok_count   <= '0;
            period_cnt <= '0;
            trigger    <= 1'b1;
            state      <= S_TRIG;
          end
          S_TRIG: begin
            if (period_cnt == TRIG_LAST) begin
              trigger <= 1'b0;
              tmo_cnt <= '0;
              state   <= S_WAIT_RISE;
            end
          end
          S_WAIT_RISE: begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (rise) begin
              presc <= PRESC_INIT;
              cm    <= '0;
              state <= S_MEASURE;
            end else if (tmo_cnt == TMO_LAST) begin
              timeout  <= 1'b1;
              ok_count <= '0;
              state    <= S_TMO;
            end
          end
          S_MEASURE: begin
            tmo_cnt <= tmo_cnt + 1'b1;
            presc   <= presc_step;
            cm      <= cm_step;
            if (fall) begin
              medida_cm     <= cm_step;
              medida_pronta <= 1'b1;
              ok_count      <= ok_next;
              state         <= S_EVAL;
            end else if (tmo_cnt == TMO_LAST) begin
              timeout  <= 1'b1;
              ok_count <= '0;
              state    <= S_TMO;
            end
          end
          S_EVAL: begin
            if (ok_count == NOK) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_WAIT_PERIOD;
            end
          end
          S_TMO: state <= S_WAIT_PERIOD;
          S_WAIT_PERIOD: begin
            if (period_cnt >= PERIOD_LAST) begin
              period_cnt <= '0;
              trigger    <= 1'b1;
              state      <= S_TRIG;
            end
          end
          S_DONE: state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_session_scheduler.sv
// Directed bench for sensor_session_scheduler with scaled timing parameters
// (10 clocks per cm, 1500-clock timeout, 2000-clock period, saturation at 120 cm).
module tb_sensor_session_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [8:0] target_cm = '0;
  logic       echo = 1'b0;
  logic       trigger, medida_pronta, timeout, done;
  logic [8:0] medida_cm;
  logic [2:0] ok_count;
  logic [3:0] db_estado;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sensor_session_scheduler #(
    .TRIGGER_CYCLES(5),
    .CM_CYCLES(10),
    .TIMEOUT_CYCLES(1500),
    .PERIOD_CYCLES(2000),
    .N_OK(5),
    .TOL_CM(2),
    .MAX_CM(120)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .target_cm(target_cm), .echo(echo),
    .trigger(trigger), .medida_cm(medida_cm), .medida_pronta(medida_pronta),
    .timeout(timeout), .ok_count(ok_count), .done(done), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic wait_trig_rise(output bit got, output int at);
    got = 1'b0;
    at  = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (trigger === 1'b1) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_trig_fall(output int width, output int at);
    width = 0;
    while (trigger === 1'b1 && width < 10000) begin
      width++;
      @(negedge clock);
    end
    at = cyc;
  endtask

  task automatic send_echo(input int delay, input int width);
    repeat (delay) @(negedge clock);
    echo = 1'b1;
    repeat (width) @(negedge clock);
    echo = 1'b0;
  endtask

  task automatic wait_pronta(output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (medida_pronta === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_round(input int width, output bit got);
    bit g1;
    int w, t;
    wait_trig_rise(g1, t);
    wait_trig_fall(w, t);
    send_echo(20, width);
    wait_pronta(got);
    got = got & g1;
  endtask

  task automatic start_session(input logic [8:0] tgt);
    enable = 1'b0;
    @(negedge clock);
    target_cm = tgt;
    enable = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({trigger, medida_cm, medida_pronta, timeout, ok_count, done, db_estado} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got trig=%b cm=%0d rdy=%b tmo=%b ok=%0d done=%b st=%0d expected all 0",
               trigger, medida_cm, medida_pronta, timeout, ok_count, done, db_estado);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (db_estado !== 4'd0 || trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_disabled: got st=%0d trig=%b expected st=0 trig=0", db_estado, trigger);
    end
  endtask

  task automatic test_first_measure;
    bit g;
    int r, w, f;
    start_session(9'd75);
    wait_trig_rise(g, r);
    vectors++;
    if (!g || db_estado !== 4'd1) begin
      miscompares++;
      $display("FAIL t1_trig_start: got seen=%b st=%0d expected seen=1 st=1", g, db_estado);
    end
    wait_trig_fall(w, f);
    vectors++;
    if (w !== 5) begin
      miscompares++;
      $display("FAIL t1_trig_width: got %0d expected 5", w);
    end
    send_echo(20, 750);
    wait_pronta(g);
    vectors++;
    if (!g || medida_cm !== 9'd75 || ok_count !== 3'd1 || db_estado !== 4'd4 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_measure: got rdy=%b cm=%0d ok=%0d st=%0d tmo=%b expected rdy=1 cm=75 ok=1 st=4 tmo=0",
               g, medida_cm, ok_count, db_estado, timeout);
    end
    @(negedge clock);
    vectors++;
    if (medida_pronta !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_pronta_width: got %b expected 0", medida_pronta);
    end
  endtask

  task automatic test_rounding;
    int widths[4]  = '{1004, 1000, 995, 994};
    int exp_cm[4]  = '{100, 100, 100, 99};
    int exp_ok[4]  = '{1, 2, 3, 4};
    bit g;
    start_session(9'd100);
    for (int i = 0; i < 4; i++) begin
      run_round(widths[i], g);
      vectors++;
      if (!g || medida_cm !== 9'(exp_cm[i]) || ok_count !== 3'(exp_ok[i])) begin
        miscompares++;
        $display("FAIL round_%0d: got rdy=%b cm=%0d ok=%0d expected rdy=1 cm=%0d ok=%0d",
                 widths[i], g, medida_cm, ok_count, exp_cm[i], exp_ok[i]);
      end
    end
  endtask

  task automatic test_window;
    int widths[4] = '{770, 780, 745, 744};
    int exp_cm[4] = '{77, 78, 75, 74};
    int exp_ok[4] = '{1, 0, 1, 2};
    bit g;
    start_session(9'd75);
    for (int i = 0; i < 4; i++) begin
      run_round(widths[i], g);
      vectors++;
      if (!g || medida_cm !== 9'(exp_cm[i]) || ok_count !== 3'(exp_ok[i])) begin
        miscompares++;
        $display("FAIL window_%0d: got rdy=%b cm=%0d ok=%0d expected rdy=1 cm=%0d ok=%0d",
                 widths[i], g, medida_cm, ok_count, exp_cm[i], exp_ok[i]);
      end
    end
  endtask

  task automatic test_saturation;
    bit g;
    start_session(9'd75);
    run_round(1300, g);
    vectors++;
    if (!g || medida_cm !== 9'd120 || ok_count !== 3'd0) begin
      miscompares++;
      $display("FAIL saturation: got rdy=%b cm=%0d ok=%0d expected rdy=1 cm=120 ok=0", g, medida_cm, ok_count);
    end
  endtask

  task automatic test_preheld_echo;
    bit g;
    int r, w, f;
    start_session(9'd75);
    wait_trig_rise(g, r);
    echo = 1'b1;
    wait_trig_fall(w, f);
    repeat (100) @(negedge clock);
    echo = 1'b0;
    repeat (5) @(negedge clock);
    vectors++;
    if (db_estado !== 4'd2) begin
      miscompares++;
      $display("FAIL preheld_state: got %0d expected 2", db_estado);
    end
    send_echo(20, 750);
    wait_pronta(g);
    vectors++;
    if (!g || medida_cm !== 9'd75 || ok_count !== 3'd1) begin
      miscompares++;
      $display("FAIL preheld_measure: got rdy=%b cm=%0d ok=%0d expected rdy=1 cm=75 ok=1", g, medida_cm, ok_count);
    end
  endtask

  task automatic test_done;
    bit g, saw;
    start_session(9'd75);
    for (int i = 0; i < 5; i++) run_round(750, g);
    vectors++;
    if (!g || ok_count !== 3'd5) begin
      miscompares++;
      $display("FAIL done_ok5: got rdy=%b ok=%0d expected rdy=1 ok=5", g, ok_count);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b1 || db_estado !== 4'd7) begin
      miscompares++;
      $display("FAIL done_set: got done=%b st=%0d expected done=1 st=7", done, db_estado);
    end
    saw = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clock);
      if (trigger !== 1'b0 || done !== 1'b1) saw = 1'b1;
    end
    vectors++;
    if (saw) begin
      miscompares++;
      $display("FAIL done_hold: got extra trigger or done drop=1 expected 0");
    end
    enable = 1'b0;
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || db_estado !== 4'd0 || ok_count !== 3'd0 || medida_cm !== 9'd75) begin
      miscompares++;
      $display("FAIL done_clear: got done=%b st=%0d ok=%0d cm=%0d expected 0 0 0 75",
               done, db_estado, ok_count, medida_cm);
    end
  endtask

  task automatic test_streak_reset;
    int widths[3] = '{750, 750, 1004};
    int exp_ok[3] = '{1, 2, 0};
    bit g;
    start_session(9'd75);
    for (int i = 0; i < 3; i++) begin
      run_round(widths[i], g);
      vectors++;
      if (!g || ok_count !== 3'(exp_ok[i])) begin
        miscompares++;
        $display("FAIL streak_%0d: got rdy=%b ok=%0d expected rdy=1 ok=%0d", i, g, ok_count, exp_ok[i]);
      end
    end
    for (int i = 0; i < 4; i++) run_round(750, g);
    @(negedge clock);
    vectors++;
    if (ok_count !== 3'd4 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL streak_four: got ok=%0d done=%b expected ok=4 done=0", ok_count, done);
    end
    run_round(750, g);
    @(negedge clock);
    vectors++;
    if (!g || done !== 1'b1) begin
      miscompares++;
      $display("FAIL streak_done: got rdy=%b done=%b expected 1 1", g, done);
    end
  endtask

  task automatic test_timeout;
    bit g, seen;
    int r1, r2, w, f, t;
    start_session(9'd75);
    run_round(750, g);
    wait_trig_rise(g, r1);
    wait_trig_fall(w, f);
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < 3000; i++) begin
      if (timeout === 1'b1) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
      @(negedge clock);
    end
    vectors++;
    if (!seen || (t - f) !== 1500) begin
      miscompares++;
      $display("FAIL timeout_delay: got seen=%b delay=%0d expected seen=1 delay=1500", seen, t - f);
    end
    vectors++;
    if (ok_count !== 3'd0 || medida_cm !== 9'd75 || db_estado !== 4'd5 || medida_pronta !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_state: got ok=%0d cm=%0d st=%0d rdy=%b expected 0 75 5 0",
               ok_count, medida_cm, db_estado, medida_pronta);
    end
    @(negedge clock);
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_width: got %b expected 0", timeout);
    end
    wait_trig_rise(g, r2);
    vectors++;
    if (!g || (r2 - r1) !== 2000) begin
      miscompares++;
      $display("FAIL period: got seen=%b interval=%0d expected seen=1 interval=2000", g, r2 - r1);
    end
  endtask

  task automatic test_abort;
    bit g;
    int r, w, f;
    start_session(9'd75);
    run_round(750, g);
    wait_trig_rise(g, r);
    wait_trig_fall(w, f);
    send_echo(20, 0);
    echo = 1'b1;
    repeat (300) @(negedge clock);
    vectors++;
    if (db_estado !== 4'd3 || ok_count !== 3'd1) begin
      miscompares++;
      $display("FAIL abort_pre: got st=%0d ok=%0d expected st=3 ok=1", db_estado, ok_count);
    end
    enable = 1'b0;
    @(negedge clock);
    vectors++;
    if (db_estado !== 4'd0 || trigger !== 1'b0 || ok_count !== 3'd0 || medida_cm !== 9'd75) begin
      miscompares++;
      $display("FAIL abort_measure: got st=%0d trig=%b ok=%0d cm=%0d expected 0 0 0 75",
               db_estado, trigger, ok_count, medida_cm);
    end
    echo = 1'b0;
    enable = 1'b1;
    wait_trig_rise(g, r);
    vectors++;
    if (!g || ok_count !== 3'd0 || db_estado !== 4'd1) begin
      miscompares++;
      $display("FAIL reenable: got seen=%b ok=%0d st=%0d expected 1 0 1", g, ok_count, db_estado);
    end
    enable = 1'b0;
    @(negedge clock);
    vectors++;
    if (trigger !== 1'b0 || db_estado !== 4'd0) begin
      miscompares++;
      $display("FAIL abort_trig: got trig=%b st=%0d expected 0 0", trigger, db_estado);
    end
    enable = 1'b1;
    wait_trig_rise(g, r);
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++;
    if ({trigger, medida_cm, medida_pronta, timeout, ok_count, done, db_estado} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got trig=%b cm=%0d rdy=%b tmo=%b ok=%0d done=%b st=%0d expected all 0",
               trigger, medida_cm, medida_pronta, timeout, ok_count, done, db_estado);
    end
    enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_first_measure();
    test_rounding();
    test_window();
    test_saturation();
    test_preheld_echo();
    test_done();
    test_streak_reset();
    test_timeout();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
